add_seq: RTL
============

Name: add_seq

Overview:
- Parametrised multi-cycle adder/subtractor built from the team's full-adder cells.
- Each cycle processes one SLICE-bit chunk of two WIDTH-bit operands, least significant chunk first, and registers the inter-slice carry.
- Serves as the area-lean arithmetic unit for lab datapaths; driven by a start/done handshake.

Parameters:
- WIDTH, 8: operand and result width in bits. Must be a multiple of SLICE.
- SLICE, 2: bits added per cycle. Must be ≥1 and ≤WIDTH.
- NSLICE, derived as WIDTH/SLICE: number of cycles per operation. Not overridable.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- op  in  1  0 = add, 1 = subtract; latched with start.
- x  in  WIDTH  operand A; latched with start.
- y  in  WIDTH  operand B; latched with start.
- ci  in  1  carry-in for add; ignored for subtract.
- busy  out  1  high while slices are being processed.
- done  out  1  single-cycle pulse: z/co are valid.
- z  out  WIDTH  result; held until the next accepted start.
- co  out  1  final carry-out; for subtract, 1 means no borrow.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset: state=IDLE; busy=0, done=0, z=0, co=0; slice counter and carry register cleared.
- Reset asserted mid-operation aborts the operation and returns to IDLE next edge. No done is produced.
- IDLE: when start=1, on that edge:
  - latch x;
  - latch y, or ~y if op=1;
  - carry register = (op ? 1 : ci);
  - counter = 0; z cleared; go to RUN.
- RUN: each edge, slice k = counter is computed as xl[k*SLICE +: SLICE] + yl[k*SLICE +: SLICE] + carry.
  - The SLICE-bit sum is written to z[k*SLICE +: SLICE]; the slice carry-out goes to the carry register.
  - counter increments.
  - After slice NSLICE-1: co = final carry, go to DONE.
- DONE: lasts exactly one cycle with done=1, then IDLE. start in DONE is accepted exactly as in IDLE (back-to-back operations).
- busy = 1 in RUN only.
- Latency: start sampled at edge E; slices at edges E+1 … E+NSLICE; done=1 in the cycle after edge E+NSLICE. For SLICE=WIDTH, done follows 2 edges after start.
- start while busy=1 is ignored. Input changes during RUN have no effect (operands are latched).
- Result: z = (x + y + ci) mod 2^WIDTH for add, and (x − y) mod 2^WIDTH for subtract. co is the true carry out of bit WIDTH−1.
- z and co are stable from done until the next accepted start clears z.

Optional Feature:
- Macro ADD_SEQ_OVF_EN.
- Defined: adds output port ovf (1 bit), reset 0, updated alongside co.
  - ovf = signed overflow of the final slice, i.e. carry into MSB XOR carry out of MSB.
  - Requires capturing the MSB carry-in inside the final slice.
- Undefined: no ovf port and no related logic; all other behaviour is identical.

Decomposition:
- Shared package add_pkg:
  - state encoding typedef (IDLE, RUN, DONE);
  - op encoding constants OP_ADD=0, OP_SUB=1.
- One sub-module, add_slice: combinational SLICE-bit ripple of fac instances via a generate loop.
  - Ports: a, b, cin, s, cout, plus cmsb (carry into the top bit) for the ovf feature.
- add_seq holds only the FSM, operand registers, counter and carry register.

Test Plan:
- Add wrap (WIDTH=8, SLICE=2): x=8'hFF, y=8'h01, ci=0, op=0, start one cycle -> busy for 4 cycles, then done pulse with z=8'h00, co=1. done is high for exactly one cycle.
- Subtract with borrow: x=8'h05, y=8'h07, op=1, ci=1 (ignored) -> z=8'hFE, co=0. Then x=8'h07, y=8'h05 -> z=8'h02, co=1.
- Start while busy: second start with x=8'h10, y=8'h10 during RUN of 8'h03+8'h04 -> ignored; single done with z=8'h07. Next, a start asserted in the DONE cycle is accepted -> z=8'h20 four cycles later.
- Reset mid-operation: assert rst at slice 2 of 8'hAA+8'h55 -> next cycle busy=0, z=0, co=0, no done. Subsequent 8'h01+8'h01 -> z=8'h02.
- Exhaustive sweep at WIDTH=4, SLICE=1 and SLICE=4: all x, y, ci, op combinations checked against a reference model. Latency is 4 and 1 slice cycles respectively.
- With ADD_SEQ_OVF_EN: 8'h7F+8'h01 -> z=8'h80, ovf=1; 8'h80−8'h01 -> z=8'h7F, ovf=1; 8'h01+8'h01 -> ovf=0.

Source files
------------

// File: rtl/add_pkg.sv
// add_pkg: shared types and constants for the sequential adder/subtractor.
//   state_t : controller states IDLE, RUN, DONE
//   OP_ADD  : op value selecting x + y + ci
//   OP_SUB  : op value selecting x - y
package add_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/add_slice.sv
// add_slice: combinational SLICE-bit ripple adder built from fac cells.
//   a, b  : SLICE-bit addends
//   cin   : carry into bit 0
//   s     : SLICE-bit sum
//   cout  : carry out of the top bit
//   cmsb  : carry into the top bit (only with ADD_SEQ_OVF_EN)
module add_slice #(
   parameter int SLICE = 2
) (
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  logic             cin,
   output logic [SLICE-1:0] s,
   output logic             cout
`ifdef ADD_SEQ_OVF_EN
   ,
   output logic             cmsb
`endif
);
   logic [SLICE:0] c;
   assign c[0] = cin;
   for (genvar i = 0; i < SLICE; i++) begin : g_fa
      fac u_fac (.a(a[i]), .b(b[i]), .ci(c[i]), .s(s[i]), .co(c[i+1]));
   end
   assign cout = c[SLICE];
`ifdef ADD_SEQ_OVF_EN
   assign cmsb = c[SLICE-1];
`endif
endmodule

// File: rtl/fac.sv
// fac: single-bit full adder cell.
//   a, b, ci : addend bits and carry-in
//   s, co    : sum bit and carry-out
module fac (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/add_seq.sv
// add_seq: multi-cycle adder/subtractor processing SLICE bits per cycle, LS slice first.
//   clk, rst      : clock and synchronous active-high reset
//   start, op     : request (taken in IDLE or DONE) and operation (0 add, 1 subtract)
//   x, y, ci      : operands and add carry-in, latched on accepted start
//   busy, done    : slices in progress / one-cycle result-valid pulse
//   z, co         : result and final carry-out (1 = no borrow on subtract)
//   ovf           : signed overflow, present only when ADD_SEQ_OVF_EN is defined
module add_seq
   import add_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SLICE = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             ci,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] z,
   output logic             co
`ifdef ADD_SEQ_OVF_EN
   ,
   output logic             ovf
`endif
);
   localparam int NSLICE = WIDTH / SLICE;
   localparam int CW = NSLICE > 1 ? $clog2(NSLICE) : 1;
   state_t state, state_n;
   logic [WIDTH-1:0] xl, yl;
   logic [CW-1:0] cnt;
   logic carry, accept, last, s_cout;
   logic [SLICE-1:0] a_sl, b_sl, s_sum;
`ifdef ADD_SEQ_OVF_EN
   logic s_cmsb;
`endif
   assign a_sl = xl[cnt*SLICE +: SLICE];
   assign b_sl = yl[cnt*SLICE +: SLICE];
   add_slice #(.SLICE(SLICE)) u_slice (
      .a(a_sl), .b(b_sl), .cin(carry), .s(s_sum), .cout(s_cout)
`ifdef ADD_SEQ_OVF_EN
      , .cmsb(s_cmsb)
`endif
   );
   // DONE accepts a new start just like IDLE, enabling back-to-back operations
   always_comb begin
      busy    = state == RUN;
      done    = state == DONE;
      accept  = start && !busy;
      last    = cnt == CW'(NSLICE - 1);
      state_n = accept ? RUN : busy ? (last ? DONE : RUN) : IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         xl    <= '0;
         yl    <= '0;
         cnt   <= '0;
         carry <= 1'b0;
         z     <= '0;
         co    <= 1'b0;
`ifdef ADD_SEQ_OVF_EN
         ovf   <= 1'b0;
`endif
      end else begin
         state <= state_n;
         if (accept) begin
            // subtract is x + ~y + 1, so the inverted operand and a forced carry-in are latched
            xl    <= x;
            yl    <= op == OP_SUB ? ~y : y;
            carry <= op == OP_ADD ? ci : 1'b1;
            cnt   <= '0;
            z     <= '0;
         end else if (busy) begin
            z[cnt*SLICE +: SLICE] <= s_sum;
            carry <= s_cout;
            cnt   <= cnt + CW'(1);
            if (last) begin
               co  <= s_cout;
`ifdef ADD_SEQ_OVF_EN
               ovf <= s_cout ^ s_cmsb;
`endif
            end
         end
      end
   end
endmodule
